shift_arbiter: RTL and testbench

- Shares one combinational 32-bit shifter unit between two requesters.
- Each requester uses a valid/ready request channel carrying operand, shift amount and shift op, plus a valid/ready response channel.
- Round-robin arbitration grants one request at a time, registers the operands, drives the shared shifter for one cycle, captures its result and returns it to the winning requester.
- Sits between the ALU-side issue logic and the shared shifter datapath.

---
 rtl/shift_arbiter.sv | 158 +++++++++++++++
 tb/tb_shift_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing one combinational 32-bit shifter
// Optional macro SHIFT_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous requests.
module shift_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_WIDTH-1:0]  req0_A,
  input  logic [SHAMT_WIDTH-1:0] req0_B,
  input  logic [1:0]             req0_op,
  output logic                   resp0_valid,
  input  logic                   resp0_ready,
  output logic [DATA_WIDTH-1:0]  resp0_result,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req1_A,
  input  logic [SHAMT_WIDTH-1:0] req1_B,
  input  logic [1:0]             req1_op,
  output logic                   resp1_valid,
  input  logic                   resp1_ready,
  output logic [DATA_WIDTH-1:0]  resp1_result,
  output logic [DATA_WIDTH-1:0]  sh_A,
  output logic [SHAMT_WIDTH-1:0] sh_B,
  output logic [1:0]             sh_Shiftop,
  input  logic [DATA_WIDTH-1:0]  sh_Result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   owner;
  logic                   owner_next;
  logic                   any_valid;
  logic                   winner;
  logic                   fire;
  logic                   take;
  logic [DATA_WIDTH-1:0]  a_reg;
  logic [SHAMT_WIDTH-1:0] b_reg;
  logic [1:0]             op_reg;
  logic [DATA_WIDTH-1:0]  result_reg;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is asking; requester 1 only when 0 is silent.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    winner    = ~req0_valid;
  end
`else
  logic ptr;

  // On a tie the pointer decides; otherwise whichever requester is asking wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      winner = ptr;
    end else begin
      winner = ~req0_valid;
    end
  end

  // After a response is taken the other requester gets priority on the next tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= ~owner;
    end
  end
`endif

  // Next-state and handshake outputs; readies are held low while reset is asserted.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    fire        = 1'b0;
    take        = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (resetn && any_valid) begin
          fire       = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          owner_next = winner;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp0_valid = ~owner;
        resp1_valid = owner;
        take        = owner ? resp1_ready : resp0_ready;
        if (take) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and owner registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Operands are captured from the winner so the requester may move on after the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
    end else if (fire) begin
      a_reg  <= winner ? req1_A  : req0_A;
      b_reg  <= winner ? req1_B  : req0_B;
      op_reg <= winner ? req1_op : req0_op;
    end
  end

  // The shifter output is sampled at the end of the single execute cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_reg <= '0;
    end else if (state == ST_EXEC) begin
      result_reg <= sh_Result;
    end
  end

  // The shared shifter always sees the operand registers; both result ports show the result register.
  always_comb begin
    sh_A         = a_reg;
    sh_B         = b_reg;
    sh_Shiftop   = op_reg;
    resp0_result = result_reg;
    resp1_result = result_reg;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter with a behavioural shift model
module tb_shift_arbiter;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  op;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_A = '0;
  logic [4:0]  req0_B = '0;
  logic [1:0]  req0_op = '0;
  logic        resp0_valid;
  logic        resp0_ready = 1'b0;
  logic [31:0] resp0_result;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_A = '0;
  logic [4:0]  req1_B = '0;
  logic [1:0]  req1_op = '0;
  logic        resp1_valid;
  logic        resp1_ready = 1'b0;
  logic [31:0] resp1_result;
  logic [31:0] sh_A;
  logic [4:0]  sh_B;
  logic [1:0]  sh_Shiftop;
  logic [31:0] sh_Result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t s0[$];
  req_t s1[$];
  logic [31:0] e0[$];
  logic [31:0] e1[$];
  int glog[$];

  bit busy = 0, owner_m = 0, ptr_m = 0;
  bit held0 = 0, held1 = 0;
  logic [31:0] held_res0, held_res1;
  logic [31:0] last0 = '0, last1 = '0;
  int fcyc = 0, fc0 = 0, fc1 = 0, done0 = 0, done1 = 0;
  bit rr_rand = 0, rr_block0 = 0, rr_block1 = 0, gap_en = 0;

  shift_arbiter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result),
    .sh_A(sh_A), .sh_B(sh_B), .sh_Shiftop(sh_Shiftop), .sh_Result(sh_Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: the shared combinational shifter.
  always_comb begin
    case (sh_Shiftop)
      2'b00:   sh_Result = sh_A << sh_B;
      2'b10:   sh_Result = sh_A >> sh_B;
      2'b11:   sh_Result = 32'($signed(sh_A) >>> sh_B);
      default: sh_Result = 32'h0;
    endcase
  end

  // Reference: repeated single-bit steps by arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
    logic [31:0] r;
    r = a;
    if (op == 2'b01) return 32'h0;
    for (int i = 0; i < int'(b); i++) begin
      case (op)
        2'b00:   r = r * 2;
        2'b10:   r = r / 2;
        default: r = {r[31], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive0();
    int seen = 0;
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (fc0 != seen) begin seen = fc0; req0_valid = 1'b0; end
      if (!req0_valid && s0.size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        r = s0.pop_front();
        req0_A = r.a; req0_B = r.b; req0_op = r.op; req0_valid = 1'b1;
      end else if (!req0_valid) begin
        req0_A = $urandom; req0_B = 5'($urandom); req0_op = 2'($urandom);
      end
      resp0_ready = rr_rand ? 1'($urandom_range(0, 1)) : !rr_block0;
    end
  endtask

  task automatic drive1();
    int seen = 0;
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (fc1 != seen) begin seen = fc1; req1_valid = 1'b0; end
      if (!req1_valid && s1.size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        r = s1.pop_front();
        req1_A = r.a; req1_B = r.b; req1_op = r.op; req1_valid = 1'b1;
      end else if (!req1_valid) begin
        req1_A = $urandom; req1_B = 5'($urandom); req1_op = 2'($urandom);
      end
      resp1_ready = rr_rand ? 1'($urandom_range(0, 1)) : !rr_block1;
    end
  endtask

  task automatic monitor();
    logic [1:0]  exp_rdy;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        e0.delete(); e1.delete();
        busy = 0; ptr_m = 0; held0 = 0; held1 = 0;
      end else begin
        if (busy) begin
          chk("ready_busy", 32'({req1_ready, req0_ready}), 32'h0);
        end else begin
          exp_rdy = 2'b00;
          if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            exp_rdy = 2'b01;
`else
            exp_rdy = ptr_m ? 2'b10 : 2'b01;
`endif
          end else if (req0_valid) begin
            exp_rdy = 2'b01;
          end else if (req1_valid) begin
            exp_rdy = 2'b10;
          end
          chk("ready_arb", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
        end
        if (busy && cyc == fcyc + 2)
          chk("latency", 32'(owner_m ? resp1_valid : resp0_valid), 32'h1);
        if (resp0_valid) begin
          chk("resp0_owner", 32'(busy && !owner_m && e0.size() != 0), 32'h1);
          if (held0) chk("resp0_stable", resp0_result, held_res0);
          if (resp0_ready && e0.size() != 0) begin
            e = e0.pop_front();
            chk("resp0_result", resp0_result, e);
            last0 = resp0_result; done0++; busy = 0; ptr_m = 1; held0 = 0;
          end else begin
            held0 = !resp0_ready; held_res0 = resp0_result;
          end
        end else begin
          if (held0) chk("resp0_held", 32'(resp0_valid), 32'h1);
          held0 = 0;
        end
        if (resp1_valid) begin
          chk("resp1_owner", 32'(busy && owner_m && e1.size() != 0), 32'h1);
          if (held1) chk("resp1_stable", resp1_result, held_res1);
          if (resp1_ready && e1.size() != 0) begin
            e = e1.pop_front();
            chk("resp1_result", resp1_result, e);
            last1 = resp1_result; done1++; busy = 0; ptr_m = 0; held1 = 0;
          end else begin
            held1 = !resp1_ready; held_res1 = resp1_result;
          end
        end else begin
          if (held1) chk("resp1_held", 32'(resp1_valid), 32'h1);
          held1 = 0;
        end
        if (req0_valid && req0_ready) begin
          e0.push_back(ref_shift(req0_A, req0_B, req0_op));
          busy = 1; owner_m = 0; fcyc = cyc; fc0++; glog.push_back(0);
        end
        if (req1_valid && req1_ready) begin
          e1.push_back(ref_shift(req1_A, req1_B, req1_op));
          busy = 1; owner_m = 1; fcyc = cyc; fc1++; glog.push_back(1);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((s0.size() != 0 || s1.size() != 0 || req0_valid || req1_valid || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout waited=%0d limit=%0d", name, n, budget);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'h0);
    chk({tag, "_valid"}, 32'({resp1_valid, resp0_valid}), 32'h0);
    chk({tag, "_res0"}, resp0_result, 32'h0);
    chk({tag, "_res1"}, resp1_result, 32'h0);
    chk({tag, "_shA"}, sh_A, 32'h0);
    chk({tag, "_shB_op"}, 32'({sh_B, sh_Shiftop}), 32'h0);
  endtask

  initial begin
    int base, d0, d1, f, n;
    fork
      monitor();
      drive0();
      drive1();
      begin
        #1000000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    resetn = 1'b1;

    s0.push_back('{32'h0000_00F0, 5'd4, 2'b00});
    wait_idle("t_req0", 50);
    chk("req0_sll", last0, 32'h0000_0F00);

    s1.push_back('{32'h8000_0000, 5'd31, 2'b11});
    wait_idle("t_req1_sra", 50);
    chk("req1_sra", last1, 32'hFFFF_FFFF);
    s1.push_back('{32'h8000_0000, 5'd31, 2'b10});
    wait_idle("t_req1_srl", 50);
    chk("req1_srl", last1, 32'h0000_0001);

    base = glog.size();
    for (int i = 0; i < 4; i++) begin
      s0.push_back('{32'h1 << i, 5'(i), 2'b00});
      s1.push_back('{32'h100 << i, 5'(i), 2'b10});
    end
    wait_idle("t_alt", 200);
    for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      chk("grant_order", 32'(glog[base + i]), (i < 4) ? 32'h0 : 32'h1);
`else
      chk("grant_order", 32'(glog[base + i]), 32'(i % 2));
`endif
    end

    rr_block0 = 1;
    s0.push_back('{32'hA5A5_0000, 5'd8, 2'b10});
    n = 0;
    while (!resp0_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_resp_seen", 32'(resp0_valid), 32'h1);
    s1.push_back('{32'h0000_0007, 5'd2, 2'b00});
    repeat (5) @(negedge clk);
    rr_block0 = 0;
    wait_idle("t_bp", 100);
    chk("bp_res0", last0, 32'h00A5_A500);
    chk("bp_res1", last1, 32'h0000_001C);

    s0.push_back('{32'h1234_5678, 5'd3, 2'b01});
    wait_idle("t_op01", 50);
    chk("op01", last0, 32'h0);

    f = fc0;
    d0 = done0;
    s0.push_back('{32'h0000_0001, 5'd1, 2'b00});
    n = 0;
    while (fc0 == f && n < 50) begin @(negedge clk); n++; end
    chk("mid_fire", 32'(fc0 - f), 32'h1);
    @(posedge clk); #2;
    resetn = 1'b0;
    s0.push_back('{32'h0000_0002, 5'd1, 2'b00});
    s1.push_back('{32'h0000_0003, 5'd1, 2'b00});
    #1;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #2;
    chk_zero("midrst_hold");
    base = glog.size();
    resetn = 1'b1;
    wait_idle("t_midrst", 100);
    chk("midrst_first_grant", 32'(glog[base]), 32'h0);
    chk("midrst_done0", 32'(done0 - d0), 32'h1);
    chk("midrst_res0", last0, 32'h0000_0004);
    chk("midrst_res1", last1, 32'h0000_0006);

    rr_rand = 1;
    gap_en = 1;
    d0 = done0;
    d1 = done1;
    for (int i = 0; i < 120; i++) begin
      s0.push_back('{32'($urandom), 5'($urandom), 2'($urandom_range(0, 3))});
      s1.push_back('{32'($urandom), 5'($urandom), 2'($urandom_range(0, 3))});
    end
    wait_idle("t_rand", 20000);
    chk("rand_done0", 32'(done0 - d0), 32'd120);
    chk("rand_done1", 32'(done1 - d1), 32'd120);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
